// File: rtl/imem_wb_slave_if.sv
// wishbone_interface: classic Wishbone bus between fetch_stage and imem_wb_slave.
// The master drives the request fields, the slave returns ack and read data.
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_mosi;
  logic        ack;
  logic [31:0] dat_miso;

  modport master (
    output cyc, stb, we, sel, adr, dat_mosi,
    input  ack, dat_miso
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_mosi,
    output ack, dat_miso
  );
endinterface

// File: rtl/imem_wb_slave.sv
// imem_wb_slave: Wishbone instruction memory feeding fetch_stage.
// Registered one-cycle ack after WAIT_STATES, byte-masked program writes.
module imem_wb_slave #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  wishbone_interface.slave wb,
  output logic             access_err
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned HW = 30 - AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic          we_q;
  logic          bad_q;
  logic [3:0]    sel_q;
  logic [31:0]   dat_q;
  logic [AW-1:0] idx_q;

  logic          req;
  logic          go_ack;
  logic          bad;
  logic          bad_rd;
  logic [HW-1:0] hi;
  logic [AW-1:0] idx;
  logic [AW-1:0] rd_idx;
  logic [1:0]    lo;

  initial begin
    for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] = NOP_WORD;
  end

  // A wrapped subtraction always leaves hi nonzero or trips adr < base.
  assign {hi, idx, lo} = wb.adr - BASE_ADDR;
  assign bad = (wb.adr < BASE_ADDR) || (hi != '0)
            || (lo != 2'b00) || (wb.adr[1:0] != 2'b00);
  assign req = wb.cyc && wb.stb;

  // Zero-wait requests read straight off the bus decode.
  assign rd_idx = (state == S_IDLE) ? idx : idx_q;
  assign bad_rd = (state == S_IDLE) ? bad : bad_q;

  always_comb begin
    go_ack = 1'b0;
    unique case (state)
      S_IDLE:  go_ack = req && (WAIT_STATES == 0);
      S_WAIT:  go_ack = wb.cyc && (cnt == 4'd1);
      default: go_ack = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wb.ack      <= 1'b0;
      wb.dat_miso <= NOP_WORD;
      access_err  <= 1'b0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      sel_q       <= '0;
      dat_q       <= '0;
      idx_q       <= '0;
    end else begin
      wb.ack     <= go_ack;
      access_err <= go_ack && bad_rd;
      if (go_ack)
        wb.dat_miso <= bad_rd ? NOP_WORD : mem[rd_idx];
      unique case (state)
        S_IDLE: begin
          if (req) begin
            we_q  <= wb.we;
            sel_q <= wb.sel;
            dat_q <= wb.dat_mosi;
            idx_q <= idx;
            bad_q <= bad;
            cnt   <= 4'(WAIT_STATES);
            state <= go_ack ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (!wb.cyc)
            state <= S_IDLE;
          else if (go_ack)
            state <= S_ACK;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Commits on the edge that ends the ack cycle; reset leaves state idle.
  always_ff @(posedge clk) begin
    if (state == S_ACK && we_q && !bad_q) begin
      for (int i = 0; i < 4; i++)
        if (sel_q[i])
          mem[idx_q][8*i +: 8] <= dat_q[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_imem_wb_slave.sv
// tb_imem_wb_slave: scoreboard bench for imem_wb_slave.
// Two instances: one wait state and three wait states.
module tb_imem_wb_slave;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        e;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        use3 = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] dat = 32'h0;
  logic        err1;
  logic        err3;
  logic        ack;
  logic        aerr;
  logic [31:0] dmiso;

  int tests = 0;
  int fails = 0;

  exp_t        sb[$];
  logic [31:0] mdl1[int];
  logic [31:0] mdl3[int];

  always #5 clk = ~clk;

  wishbone_interface b1();
  wishbone_interface b3();

  assign b1.cyc      = cyc & ~use3;
  assign b1.stb      = stb;
  assign b1.we       = we;
  assign b1.sel      = sel;
  assign b1.adr      = adr;
  assign b1.dat_mosi = dat;
  assign b3.cyc      = cyc & use3;
  assign b3.stb      = stb;
  assign b3.we       = we;
  assign b3.sel      = sel;
  assign b3.adr      = adr;
  assign b3.dat_mosi = dat;

  assign ack   = use3 ? b3.ack : b1.ack;
  assign aerr  = use3 ? err3 : err1;
  assign dmiso = use3 ? b3.dat_miso : b1.dat_miso;

  imem_wb_slave #(.DEPTH_WORDS(4096), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wb(b1), .access_err(err1)
  );

  imem_wb_slave #(.DEPTH_WORDS(4096), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .wb(b3), .access_err(err3)
  );

  function automatic logic is_bad(input logic [31:0] a);
    return (a >= 32'h0000_4000) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    int k = int'(a >> 2);
    if (use3) return mdl3.exists(k) ? mdl3[k] : NOP;
    return mdl1.exists(k) ? mdl1[k] : NOP;
  endfunction

  function automatic exp_t predict(input logic [31:0] a);
    exp_t x;
    x.e = is_bad(a);
    x.d = x.e ? NOP : mrd(a);
    return x;
  endfunction

  task automatic model_write(input logic w, input logic [3:0] s,
                             input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    int k;
    if (w && !is_bad(a)) begin
      v = mrd(a);
      k = int'(a >> 2);
      for (int i = 0; i < 4; i++)
        if (s[i]) v[8*i +: 8] = d[8*i +: 8];
      if (use3) mdl3[k] = v;
      else mdl1[k] = v;
    end
  endtask

  task automatic xfer(input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd,
                      output logic e, output logic ack2);
    @(posedge clk); #1;
    we = w; sel = s; adr = a; dat = d;
    cyc = 1'b1; stb = 1'b1;
    sb.push_back(predict(a));
    model_write(w, s, a, d);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 20);
    rd = dmiso;
    e = aerr;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    ack2 = ack;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (b1.ack !== 1'b0 || b3.ack !== 1'b0) begin
      fails++; $display("FAIL reset_ack got %b/%b want 0", b1.ack, b3.ack);
    end
    tests++;
    if (b1.dat_miso !== NOP || b3.dat_miso !== NOP) begin
      fails++;
      $display("FAIL reset_dat got %h/%h want %h", b1.dat_miso, b3.dat_miso, NOP);
    end
    tests++;
    if (err1 !== 1'b0 || err3 !== 1'b0) begin
      fails++; $display("FAIL reset_err got %b/%b want 0", err1, err3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_read();
    int lat; logic [31:0] rd; logic e, a2; exp_t x;
    use3 = 1'b0;
    xfer(1'b0, 4'hf, 32'h0000_000c, 32'h0, lat, rd, e, a2);
    x = sb.pop_front();
    tests++;
    if (rd !== x.d || e !== x.e) begin
      fails++; $display("FAIL empty_read got %h/%b want %h/%b", rd, e, x.d, x.e);
    end
    xfer(1'b1, 4'hf, 32'h0, 32'h0050_0093, lat, rd, e, a2);
    x = sb.pop_front();
    xfer(1'b0, 4'hf, 32'h0, 32'h0, lat, rd, e, a2);
    x = sb.pop_front();
    tests++;
    if (lat !== 2) begin
      fails++; $display("FAIL read_latency got %0d want 2", lat);
    end
    tests++;
    if (rd !== x.d || rd !== 32'h0050_0093) begin
      fails++; $display("FAIL read_data got %h want %h", rd, x.d);
    end
    tests++;
    if (e !== 1'b0) begin
      fails++; $display("FAIL read_err got %b want 0", e);
    end
    tests++;
    if (a2 !== 1'b0) begin
      fails++; $display("FAIL ack_width ack still %b one cycle later", a2);
    end
  endtask

  task automatic test_back_to_back();
    int lat, n_ack, gap, cyc_cnt;
    logic [31:0] rd; logic e, a2, prev; exp_t x;
    logic [31:0] seq [4];
    use3 = 1'b0;
    seq[0] = 32'h0; seq[1] = 32'h4; seq[2] = 32'h4; seq[3] = 32'h8;
    xfer(1'b1, 4'hf, 32'h4, 32'haaaa_0001, lat, rd, e, a2);
    x = sb.pop_front();
    xfer(1'b1, 4'hf, 32'h8, 32'hbbbb_0002, lat, rd, e, a2);
    x = sb.pop_front();
    @(posedge clk); #1;
    we = 1'b0; sel = 4'hf; adr = seq[0]; cyc = 1'b1; stb = 1'b1;
    sb.push_back(predict(adr));
    n_ack = 0; gap = 0; cyc_cnt = 0; prev = 1'b0;
    while (n_ack < 4 && cyc_cnt < 60) begin
      @(posedge clk); #1;
      cyc_cnt++; gap++;
      if (ack) begin
        tests++;
        if (prev) begin
          fails++; $display("FAIL b2b_consec ack high two cycles at ack %0d", n_ack);
        end
        if (n_ack > 0) begin
          tests++;
          if (gap != 3) begin
            fails++; $display("FAIL b2b_gap got %0d want 3", gap);
          end
        end
        x = sb.pop_front();
        tests++;
        if (dmiso !== x.d || aerr !== x.e) begin
          fails++;
          $display("FAIL b2b_data[%0d] got %h/%b want %h/%b", n_ack, dmiso, aerr, x.d, x.e);
        end
        n_ack++; gap = 0;
        if (n_ack < 4) begin
          adr = seq[n_ack];
          sb.push_back(predict(adr));
        end else begin
          cyc = 1'b0; stb = 1'b0;
        end
      end
      prev = ack;
    end
    tests++;
    if (n_ack != 4) begin
      fails++; $display("FAIL b2b_timeout got %0d acks want 4", n_ack);
    end
    cyc = 1'b0; stb = 1'b0;
    sb.delete();
  endtask

  task automatic test_bad_addr();
    int lat; logic [31:0] rd; logic e, a2; exp_t x;
    logic [31:0] addrs [3];
    use3 = 1'b0;
    addrs[0] = 32'h0000_4000; addrs[1] = 32'h0000_0002; addrs[2] = 32'h0000_3ffc;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 4'hf, addrs[i], 32'h0, lat, rd, e, a2);
      x = sb.pop_front();
      tests++;
      if (rd !== x.d || e !== x.e || lat !== 2) begin
        fails++;
        $display("FAIL bad_read[%h] got %h/%b lat %0d want %h/%b lat 2",
                 addrs[i], rd, e, lat, x.d, x.e);
      end
    end
    xfer(1'b1, 4'hf, 32'h9, 32'hffff_ffff, lat, rd, e, a2);
    x = sb.pop_front();
    tests++;
    if (e !== 1'b1 || lat !== 2) begin
      fails++; $display("FAIL bad_write err %b lat %0d want 1 lat 2", e, lat);
    end
    xfer(1'b0, 4'hf, 32'h8, 32'h0, lat, rd, e, a2);
    x = sb.pop_front();
    tests++;
    if (rd !== x.d) begin
      fails++; $display("FAIL bad_write_mem got %h want %h", rd, x.d);
    end
  endtask

  task automatic test_byte_write();
    int lat; logic [31:0] rd; logic e, a2; exp_t x;
    use3 = 1'b0;
    xfer(1'b1, 4'hf, 32'h8, 32'h1111_1111, lat, rd, e, a2);
    x = sb.pop_front();
    xfer(1'b1, 4'b0101, 32'h8, 32'hdead_beef, lat, rd, e, a2);
    x = sb.pop_front();
    tests++;
    if (rd !== x.d || e !== 1'b0) begin
      fails++; $display("FAIL write_ack_data got %h/%b want %h/0", rd, e, x.d);
    end
    xfer(1'b0, 4'h0, 32'h8, 32'h0, lat, rd, e, a2);
    x = sb.pop_front();
    tests++;
    if (rd !== x.d || rd !== 32'h11ad_11ef) begin
      fails++; $display("FAIL byte_merge got %h want 11ad11ef", rd);
    end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic e, a2, seen; exp_t x;
    use3 = 1'b1;
    xfer(1'b1, 4'hf, 32'h8, 32'h1234_5678, lat, rd, e, a2);
    x = sb.pop_front();
    tests++;
    if (lat !== 4) begin
      fails++; $display("FAIL w3_latency got %0d want 4", lat);
    end
    @(posedge clk); #1;
    we = 1'b1; sel = 4'hf; adr = 32'h8; dat = 32'hcafe_f00d;
    cyc = 1'b1; stb = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | ack;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL abort_ack got ack %b want 0", seen);
    end
    xfer(1'b0, 4'hf, 32'h8, 32'h0, lat, rd, e, a2);
    x = sb.pop_front();
    tests++;
    if (rd !== x.d || lat !== 4 || e !== 1'b0) begin
      fails++;
      $display("FAIL abort_mem got %h lat %0d want %h lat 4", rd, lat, x.d);
    end
    use3 = 1'b0;
  endtask

  task automatic test_reset_ack();
    int lat, n; logic [31:0] rd; logic e, a2; exp_t x;
    use3 = 1'b0;
    xfer(1'b1, 4'hf, 32'hc, 32'h7777_7777, lat, rd, e, a2);
    x = sb.pop_front();
    @(posedge clk); #1;
    we = 1'b1; sel = 4'hf; adr = 32'hc; dat = 32'h0; cyc = 1'b1; stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 20);
    tests++;
    if (!ack) begin
      fails++; $display("FAIL rst_ack_timeout got no ack want ack");
    end
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1;
    tests++;
    if (b1.ack !== 1'b0 || b1.dat_miso !== NOP || err1 !== 1'b0) begin
      fails++;
      $display("FAIL rst_in_ack got %b/%h/%b want 0/%h/0", b1.ack, b1.dat_miso, err1, NOP);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, 4'hf, 32'hc, 32'h0, lat, rd, e, a2);
    x = sb.pop_front();
    tests++;
    if (rd !== x.d || rd !== 32'h7777_7777) begin
      fails++; $display("FAIL rst_no_write got %h want 77777777", rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_bad_addr();
    test_byte_write();
    test_abort();
    test_reset_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
